narrow_sat_unit: RTL and testbench

- Pipelined narrowing unit. It converts an IN_W-bit datapath word down to an OUT_W-bit field, either by truncation or by saturation.
- It is the inverse direction of the datapath's field sign/zero-extenders: it produces shift-amount, immediate-encode and register-index fields from full-width values.
- It reports lossy conversions through a per-result flag, a sticky flag and a saturating counter.
- It also returns the narrowed value re-extended to IN_W, so consumers and the bench can check the round trip.

---
 rtl/narrow_pkg.sv | 23 ++
 rtl/narrow_core.sv | 69 ++++++
 rtl/narrow_sat_unit.sv | 133 +++++++++++++
 tb/tb_narrow_sat_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/narrow_pkg.sv
// narrow_pkg: shared definitions for the narrowing unit.
//   - mode_t and the four conversion mode encodings
//   - default datapath, field and counter widths
//   - mode_is_signed(): whether a mode re-extends its field as signed
package narrow_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_TRUNC = 2'b00;
  localparam mode_t MODE_SSAT  = 2'b01;
  localparam mode_t MODE_USAT  = 2'b10;
  localparam mode_t MODE_S2U   = 2'b11;

  localparam int unsigned DEF_IN_W  = 32;
  localparam int unsigned DEF_OUT_W = 5;
  localparam int unsigned DEF_CNT_W = 8;

  // Truncate and signed-saturate produce signed fields; the other two are unsigned.
  function automatic logic mode_is_signed(input mode_t mode);
    return ~mode[1];
  endfunction

endpackage

// File: rtl/narrow_core.sv
// narrow_core: combinational IN_W -> OUT_W narrowing.
//   data  : word to narrow
//   mode  : conversion mode (see narrow_pkg)
//   field : narrowed OUT_W-bit result
//   ext   : field re-extended to IN_W (signed modes sign-extend, others zero-extend)
//   ovf   : the conversion lost information
module narrow_core
  import narrow_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  data,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] field,
  output logic [IN_W-1:0]  ext,
  output logic             ovf
);

  localparam logic [OUT_W-1:0] SMax = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMin = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] UMax = {OUT_W{1'b1}};

  logic [IN_W-OUT_W:0] upper_s;
  logic                fits_s;
  logic                fits_u;
  logic                neg;

  // A value fits OUT_W signed bits when every bit from the field MSB upward agrees.
  assign upper_s = data[IN_W-1:OUT_W-1];
  assign fits_s  = (&upper_s) | ~(|upper_s);
  assign fits_u  = ~(|data[IN_W-1:OUT_W]);
  assign neg     = data[IN_W-1];

  always_comb begin
    field = data[OUT_W-1:0];
    ovf   = 1'b0;
    case (mode)
      MODE_TRUNC: begin
        ovf = ~fits_s;
      end
      MODE_SSAT: begin
        if (!fits_s) begin
          field = neg ? SMin : SMax;
          ovf   = 1'b1;
        end
      end
      MODE_USAT: begin
        if (!fits_u) begin
          field = UMax;
          ovf   = 1'b1;
        end
      end
      default: begin
        // Negative inputs never fit unsigned, so they are caught before the upper clamp.
        if (neg) begin
          field = '0;
          ovf   = 1'b1;
        end else if (!fits_u) begin
          field = UMax;
          ovf   = 1'b1;
        end
      end
    endcase
  end

  assign ext = {{(IN_W-OUT_W){field[OUT_W-1] & mode_is_signed(mode)}}, field};

endmodule

// File: rtl/narrow_sat_unit.sv
// narrow_sat_unit: two-stage pipelined narrowing unit with valid/ready handshake.
//   Clk, Reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_data, in_mode sampled on acceptance
//   out_valid/out_ready  : output handshake; out_data, out_ext, out_ovf held while stalled
//   clr_sticky           : clear ovf_sticky and ovf_count
//   ovf_sticky/ovf_count : overflow history of delivered results (count saturates)
module narrow_sat_unit
  import narrow_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IN_W-1:0]  out_ext,
  output logic             out_ovf,
  input  logic             clr_sticky,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  s1_data_q, s1_data_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [IN_W-1:0]  out_ext_q, out_ext_d;
  logic             out_ovf_q, out_ovf_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             advance;
  logic             xfer;
  logic [OUT_W-1:0] core_field;
  logic [IN_W-1:0]  core_ext;
  logic             core_ovf;

  narrow_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .data  (s1_data_q),
    .mode  (s1_mode_q),
    .field (core_field),
    .ext   (core_ext),
    .ovf   (core_ovf)
  );

  // The whole pipe moves together; any stall at the output freezes both stages.
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;
  assign xfer     = out_valid_q & out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ext_d   = out_ext_q;
    out_ovf_d   = out_ovf_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_mode_d = in_mode;
      end
      if (s1_valid_q) begin
        out_data_d = core_field;
        out_ext_d  = core_ext;
        out_ovf_d  = core_ovf;
      end
    end
  end

  // An overflowing delivery takes priority over a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (xfer && out_ovf_q) begin
      sticky_d = 1'b1;
      if (clr_sticky) begin
        count_d = CNT_W'(1);
      end else if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ext_q   <= '0;
      out_ovf_q   <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ext_q   <= out_ext_d;
      out_ovf_q   <= out_ovf_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ext    = out_ext_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;
  assign ovf_count  = count_q;

endmodule

// File: tb/tb_narrow_sat_unit.sv
// Bench for narrow_sat_unit: a default-width instance plus a CNT_W=2 instance fed the same
// stimulus. A reference model predicts every cycle; directed tasks pin literal values.
module tb_narrow_sat_unit;

  localparam int IW = 32;
  localparam int OW = 5;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic [1:0]    in_mode = '0;
  logic          out_ready = 1'b1;
  logic          clr_sticky = 1'b0;

  logic          in_ready, out_valid, out_ovf, ovf_sticky;
  logic [OW-1:0] out_data;
  logic [IW-1:0] out_ext;
  logic [7:0]    ovf_count;

  logic          in_ready2, out_valid2, out_ovf2, ovf_sticky2;
  logic [OW-1:0] out_data2;
  logic [IW-1:0] out_ext2;
  logic [1:0]    ovf_count2;

  narrow_sat_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ext    (out_ext),
    .out_ovf    (out_ovf),
    .clr_sticky (clr_sticky),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  narrow_sat_unit #(
    .CNT_W (2)
  ) dut2 (
    .Clk        (Clk),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid2),
    .out_ready  (out_ready),
    .out_data   (out_data2),
    .out_ext    (out_ext2),
    .out_ovf    (out_ovf2),
    .clr_sticky (clr_sticky),
    .ovf_sticky (ovf_sticky2),
    .ovf_count  (ovf_count2)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [OW-1:0] f;
    logic [IW-1:0] e;
    logic          o;
  } exp_t;

  // Narrowing from the arithmetic definition of each mode on a wide integer.
  function automatic exp_t model(input logic [IW-1:0] d, input logic [1:0] m);
    exp_t   r;
    longint sv, uv, lo, hi, umax, v;
    sv   = longint'($signed(d));
    uv   = longint'(d);
    lo   = -(longint'(1) << (OW - 1));
    hi   = (longint'(1) << (OW - 1)) - 1;
    umax = (longint'(1) << OW) - 1;
    case (m)
      2'b00: begin
        v = sv & umax;
        if (v > hi) v = v - umax - 1;
        r.o = (sv < lo) || (sv > hi);
      end
      2'b01: begin
        v   = (sv < lo) ? lo : ((sv > hi) ? hi : sv);
        r.o = (sv < lo) || (sv > hi);
      end
      2'b10: begin
        v   = (uv > umax) ? umax : uv;
        r.o = uv > umax;
      end
      default: begin
        v   = (sv < 0) ? 0 : ((sv > umax) ? umax : sv);
        r.o = (sv < 0) || (sv > umax);
      end
    endcase
    r.f = v[OW-1:0];
    r.e = v[IW-1:0];
    return r;
  endfunction

  // Scoreboard: results in flight, the cycle the head becomes visible, overflow history.
  exp_t q[$];
  exp_t e_new;
  int   cyc = 0;
  int   head_vis = 0;
  int   delivered = 0;
  bit   exp_valid, xfer, xovf;
  bit   m_sticky = 0;
  int   m_cnt = 0;
  int   m_cnt2 = 0;

  always @(negedge Clk) begin
    exp_valid = (q.size() > 0) && (cyc >= head_vis);
    check("out_valid", {63'b0, out_valid}, {63'b0, exp_valid});
    check("in_ready", {63'b0, in_ready}, {63'b0, (!exp_valid || out_ready)});
    check("out_valid_cnt2", {63'b0, out_valid2}, {63'b0, exp_valid});
    if (exp_valid) begin
      check("out_data", {59'b0, out_data}, {59'b0, q[0].f});
      check("out_ext", {32'b0, out_ext}, {32'b0, q[0].e});
      check("out_ovf", {63'b0, out_ovf}, {63'b0, q[0].o});
    end
    check("ovf_sticky", {63'b0, ovf_sticky}, {63'b0, m_sticky});
    check("ovf_count", {56'b0, ovf_count}, 64'(m_cnt));
    check("ovf_sticky_cnt2", {63'b0, ovf_sticky2}, {63'b0, m_sticky});
    check("ovf_count_cnt2", {62'b0, ovf_count2}, 64'(m_cnt2));

    // Predict the effect of the coming rising edge from the inputs now present.
    if (Reset) begin
      q.delete();
      m_sticky = 0;
      m_cnt    = 0;
      m_cnt2   = 0;
    end else begin
      xfer = exp_valid && out_ready;
      xovf = 0;
      if (xfer) begin
        xovf = q[0].o;
        void'(q.pop_front());
        delivered++;
        if (q.size() > 0) head_vis = cyc + 1;
      end
      if (xfer && xovf) begin
        m_sticky = 1;
        m_cnt    = clr_sticky ? 1 : ((m_cnt < 255) ? m_cnt + 1 : m_cnt);
        m_cnt2   = clr_sticky ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2);
      end else if (clr_sticky) begin
        m_sticky = 0;
        m_cnt    = 0;
        m_cnt2   = 0;
      end
      if (in_valid && (!exp_valid || out_ready)) begin
        e_new = model(in_data, in_mode);
        if (q.size() == 0) head_vis = cyc + 2;
        q.push_back(e_new);
      end
    end
    cyc++;
  end

  // One word through an idle pipe with out_ready=1; optional clr_sticky on its transfer edge.
  task automatic send_one(input logic [IW-1:0] d, input logic [1:0] m,
                          input logic [OW-1:0] ef, input logic [IW-1:0] ee, input logic eo,
                          input logic with_clr);
    @(posedge Clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge Clk);
    check("lit_accept_ready", {63'b0, in_ready}, 64'd1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    @(negedge Clk);
    check("lit_lat1_valid", {63'b0, out_valid}, 64'd0);
    @(posedge Clk);
    #1;
    clr_sticky = with_clr;
    @(negedge Clk);
    check("lit_lat2_valid", {63'b0, out_valid}, 64'd1);
    check("lit_out_data", {59'b0, out_data}, {59'b0, ef});
    check("lit_out_ext", {32'b0, out_ext}, {32'b0, ee});
    check("lit_out_ovf", {63'b0, out_ovf}, {63'b0, eo});
  endtask

  logic [IW-1:0] bp_d[4];
  bit            bp_acc;
  int            bp_guard;
  int            dl_start;

  initial begin
    bp_d[0] = 32'h0000_0005;
    bp_d[1] = 32'hFFFF_FFFF;
    bp_d[2] = 32'h0000_0011;
    bp_d[3] = 32'hFFFF_FFE0;

    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("lit_reset_out_data", {59'b0, out_data}, 64'd0);
    check("lit_reset_out_ext", {32'b0, out_ext}, 64'd0);
    check("lit_reset_in_ready", {63'b0, in_ready}, 64'd1);

    send_one(32'h0000_0013, 2'b01, 5'h0F, 32'h0000_000F, 1'b1, 1'b0);
    @(negedge Clk);
    check("lit_first_count", {56'b0, ovf_count}, 64'd1);
    send_one(32'hFFFF_FFF0, 2'b01, 5'h10, 32'hFFFF_FFF0, 1'b0, 1'b0);
    send_one(32'h0000_0023, 2'b00, 5'h03, 32'h0000_0003, 1'b1, 1'b0);
    send_one(32'h0000_0040, 2'b10, 5'h1F, 32'h0000_001F, 1'b1, 1'b0);
    send_one(32'h8000_0000, 2'b11, 5'h00, 32'h0000_0000, 1'b1, 1'b0);
    send_one(32'h0000_0007, 2'b11, 5'h07, 32'h0000_0007, 1'b0, 1'b0);

    // Backpressure: four words against a 5-cycle stall.
    @(posedge Clk);
    #1 out_ready = 1'b0;
    dl_start = delivered;
    fork
      begin
        repeat (5) @(posedge Clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          in_valid = 1'b1;
          in_data  = bp_d[i];
          in_mode  = 2'b01;
          bp_guard = 0;
          do begin
            @(negedge Clk);
            bp_acc = in_ready;
            @(posedge Clk);
            #1;
            bp_guard++;
          end while (!bp_acc && bp_guard < 20);
          if (!bp_acc) check("bp_accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
      end
      begin
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        check("lit_bp_in_ready_low", {63'b0, in_ready}, 64'd0);
      end
    join
    repeat (6) @(negedge Clk);
    check("bp_all_delivered", 64'(delivered - dl_start), 64'd4);

    // Counter saturation on the 2-bit instance, then clear racing an overflow.
    @(posedge Clk);
    #1 clr_sticky = 1'b1;
    @(posedge Clk);
    #1 clr_sticky = 1'b0;
    @(negedge Clk);
    check("lit_clr_count", {56'b0, ovf_count}, 64'd0);
    check("lit_clr_sticky", {63'b0, ovf_sticky}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      send_one(32'h0000_0040, 2'b10, 5'h1F, 32'h0000_001F, 1'b1, 1'b0);
    end
    @(negedge Clk);
    check("lit_cnt2_saturated", {62'b0, ovf_count2}, 64'd3);
    check("lit_cnt8_five", {56'b0, ovf_count}, 64'd5);
    send_one(32'h0000_0040, 2'b10, 5'h1F, 32'h0000_001F, 1'b1, 1'b1);
    @(posedge Clk);
    #1 clr_sticky = 1'b0;
    @(negedge Clk);
    check("lit_clr_vs_ovf_sticky", {63'b0, ovf_sticky}, 64'd1);
    check("lit_clr_vs_ovf_count", {56'b0, ovf_count}, 64'd1);
    check("lit_clr_vs_ovf_count2", {62'b0, ovf_count2}, 64'd1);

    // Reset with both stages full.
    @(posedge Clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0040;
    in_mode   = 2'b10;
    @(posedge Clk);
    #1;
    in_data = 32'h0000_0013;
    in_mode = 2'b01;
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    @(negedge Clk);
    check("lit_pre_reset_valid", {63'b0, out_valid}, 64'd1);
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("lit_mid_reset_valid", {63'b0, out_valid}, 64'd0);
    check("lit_mid_reset_ready", {63'b0, in_ready}, 64'd1);
    check("lit_mid_reset_count", {56'b0, ovf_count}, 64'd0);
    check("lit_mid_reset_data", {59'b0, out_data}, 64'd0);
    @(posedge Clk);
    #1 out_ready = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      check("lit_no_stale", {63'b0, out_valid}, 64'd0);
    end
    send_one(32'hFFFF_FFF0, 2'b11, 5'h00, 32'h0000_0000, 1'b1, 1'b0);
    repeat (2) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
